// File: rtl/fsbm_pkg.sv
// Shared constants and state encoding for the full-search block-matching controller.
package fsbm_pkg;

    localparam int NPIX       = 16;
    localparam int SAD_W      = 12;
    localparam int MV_W       = 8;
    localparam int BLK_CYCLES = 21;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLR   = 3'd1;
    localparam state_t ST_FETCH = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_CMP   = 3'd4;
    localparam state_t ST_CAPT  = 3'd5;
    localparam state_t ST_RES   = 3'd6;

    // True when idx is the final block of a frame holding n blocks.
    function automatic logic is_last_blk(input logic [5:0] idx, input logic [6:0] n);
        return ({1'b0, idx} + 7'd1) >= n;
    endfunction

endpackage

// File: rtl/fsbm_pix_cnt.sv
// Current-block pixel address counter; wraps to zero after the last pixel.
module fsbm_pix_cnt #(
    parameter int NPIX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       tc
);

    localparam logic [3:0] LAST = 4'(NPIX - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clr || (en && tc)) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/fsbm_search_ctrl.sv
// Frame-level sequencer for a 16-PE full-search motion estimator: fetch, accumulate,
// compare and report one 4x4 block every 21 cycles.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | clear SAD accumulators
// FETCH | read NPIX current-block pixels, one per cycle
// DRAIN | last read returns, final accumulate
// CMP   | pulse minimum comparator
// CAPT  | comparator result settles, captured at end of cycle
// RES   | report result; next block or frame end
module fsbm_search_ctrl #(
    parameter int NPIX  = fsbm_pkg::NPIX,
    parameter int SAD_W = fsbm_pkg::SAD_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [6:0]                nblk,
    output logic                      busy,
    output logic [3:0]                pix_addr,
    output logic                      mem_rd,
    output logic                      pe_clr,
    output logic                      pe_acc,
    output logic                      cmp_en,
    input  logic [fsbm_pkg::MV_W-1:0] cmp_mv,
    input  logic [SAD_W-1:0]          cmp_mad,
    output logic [5:0]                blk_idx,
    output logic [fsbm_pkg::MV_W-1:0] mv_out,
    output logic [SAD_W-1:0]          mad_out,
    output logic                      res_valid,
    output logic                      done
);

    import fsbm_pkg::*;

    state_t     state;
    state_t     nxt;
    logic [6:0] nblk_q;
    logic       pix_tc;
    logic       launch;
    logic       empty_frame;
    logic       abort_hit;

    assign launch      = (state == ST_IDLE) && start && (nblk != 7'd0);
    assign empty_frame = (state == ST_IDLE) && start && (nblk == 7'd0);
    assign abort_hit   = abort && (state != ST_IDLE);

    fsbm_pix_cnt #(
        .NPIX (NPIX)
    ) u_pix_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort_hit || (state != ST_FETCH)),
        .en    (state == ST_FETCH),
        .cnt   (pix_addr),
        .tc    (pix_tc)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (launch) nxt = ST_CLR;
            ST_CLR:   nxt = ST_FETCH;
            ST_FETCH: if (pix_tc) nxt = ST_DRAIN;
            ST_DRAIN: nxt = ST_CMP;
            ST_CMP:   nxt = ST_CAPT;
            ST_CAPT:  nxt = ST_RES;
            ST_RES:   nxt = is_last_blk(blk_idx, nblk_q) ? ST_IDLE : ST_CLR;
            default:  nxt = ST_IDLE;
        endcase
        if (abort_hit) begin
            nxt = ST_IDLE;
        end
    end

    // Strobes are registered from the next state so every output comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            pe_clr    <= 1'b0;
            mem_rd    <= 1'b0;
            pe_acc    <= 1'b0;
            cmp_en    <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            busy      <= (nxt != ST_IDLE);
            pe_clr    <= (nxt == ST_CLR);
            mem_rd    <= (nxt == ST_FETCH);
            pe_acc    <= mem_rd && (nxt != ST_IDLE);
            cmp_en    <= (nxt == ST_CMP);
            res_valid <= (nxt == ST_RES);
            done      <= ((nxt == ST_RES) && is_last_blk(blk_idx, nblk_q)) || empty_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_idx <= 6'd0;
            nblk_q  <= 7'd0;
        end else if (launch) begin
            blk_idx <= 6'd0;
            nblk_q  <= nblk;
        end else if ((state == ST_RES) && (nxt == ST_CLR)) begin
            blk_idx <= blk_idx + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_out  <= '0;
            mad_out <= '0;
        end else if ((state == ST_CAPT) && (nxt == ST_RES)) begin
            mv_out  <= cmp_mv;
            mad_out <= cmp_mad;
        end
    end

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// Self-checking bench for fsbm_search_ctrl against a per-block timeline model.
module tb_fsbm_search_ctrl;

    localparam int SW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [6:0]    nblk = 7'd0;
    logic          busy;
    logic [3:0]    pix_addr;
    logic          mem_rd;
    logic          pe_clr;
    logic          pe_acc;
    logic          cmp_en;
    logic [7:0]    cmp_mv = 8'd0;
    logic [SW-1:0] cmp_mad = '0;
    logic [5:0]    blk_idx;
    logic [7:0]    mv_out;
    logic [SW-1:0] mad_out;
    logic          res_valid;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]    prev_mv = 8'd0;
    logic [SW-1:0] prev_mad = '0;
    logic          fix_en = 1'b0;
    logic [7:0]    fix_mv = 8'd0;
    logic [SW-1:0] fix_mad = '0;

    fsbm_search_ctrl #(
        .NPIX  (16),
        .SAD_W (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .nblk      (nblk),
        .busy      (busy),
        .pix_addr  (pix_addr),
        .mem_rd    (mem_rd),
        .pe_clr    (pe_clr),
        .pe_acc    (pe_acc),
        .cmp_en    (cmp_en),
        .cmp_mv    (cmp_mv),
        .cmp_mad   (cmp_mad),
        .blk_idx   (blk_idx),
        .mv_out    (mv_out),
        .mad_out   (mad_out),
        .res_valid (res_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strb();
        return {busy, pe_clr, mem_rd, pe_acc, cmp_en, res_valid, done};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "/strb"}, 32'(strb()), 32'd0);
        chk({tag, "/pix"}, 32'(pix_addr), 32'd0);
        chk({tag, "/mv"}, 32'(mv_out), 32'(prev_mv));
        chk({tag, "/mad"}, 32'(mad_out), 32'(prev_mad));
    endtask

    // Launch one frame and follow it cycle by cycle. abort_k / start_k / rst_k give the
    // cycle index (from the first CLR cycle) at which to inject that event; -1 for none.
    task automatic run_frame(input int n, input int abort_k, input int start_k, input int rst_k);
        int            total;
        int            b;
        int            t;
        int            rv_cnt;
        int            dn_cnt;
        logic [6:0]    exp_s;
        logic [7:0]    cur_mv;
        logic [SW-1:0] cur_mad;
        @(negedge clk);
        nblk  = 7'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            chk("nb0/strb", 32'(strb()), 32'b0000001);
            @(negedge clk);
            chk_idle("nb0/after");
            return;
        end
        total   = 21 * n;
        rv_cnt  = 0;
        dn_cnt  = 0;
        cur_mv  = prev_mv;
        cur_mad = prev_mad;
        for (int k = 0; k < total; k++) begin
            b = k / 21;
            t = (k % 21) + 1;
            exp_s = {1'b1, t == 1, (t >= 2) && (t <= 17), (t >= 3) && (t <= 18),
                     t == 19, t == 21, (t == 21) && (b == n - 1)};
            chk("strb", 32'(strb()), 32'(exp_s));
            chk("pix", 32'(pix_addr), ((t >= 2) && (t <= 17)) ? 32'(t - 2) : 32'd0);
            chk("blk", 32'(blk_idx), 32'(b));
            chk("mv", 32'(mv_out), (t == 21) ? 32'(cur_mv) : 32'(prev_mv));
            chk("mad", 32'(mad_out), (t == 21) ? 32'(cur_mad) : 32'(prev_mad));
            if (t == 21) begin
                prev_mv  = cur_mv;
                prev_mad = cur_mad;
            end
            rv_cnt += int'(res_valid);
            dn_cnt += int'(done);
            if (t == 1) begin
                if (fix_en) begin
                    cur_mv  = fix_mv;
                    cur_mad = fix_mad;
                end else begin
                    cur_mv  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
                    cur_mad = SW'($urandom);
                end
                cmp_mv  = cur_mv;
                cmp_mad = cur_mad;
            end
            start = (k == start_k);
            if (k == abort_k) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                chk_idle("abort");
                @(negedge clk);
                chk_idle("abort+1");
                return;
            end
            if (k == rst_k) begin
                #2 rst_n = 1'b0;
                #1;
                prev_mv  = 8'd0;
                prev_mad = '0;
                chk_idle("rst");
                chk("rst/blk", 32'(blk_idx), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk_idle("end");
        chk("rv_cnt", 32'(rv_cnt), 32'(n));
        chk("done_cnt", 32'(dn_cnt), 32'd1);
    endtask

    initial begin
        int n;
        int ak;
        int sk;
        #1 rst_n = 1'b0;
        #2;
        chk_idle("por");
        chk("por/blk", 32'(blk_idx), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single block with fixed comparator answer
        fix_en  = 1'b1;
        fix_mv  = 8'h21;
        fix_mad = SW'(37);
        run_frame(1, -1, -1, -1);
        chk("single/mv", 32'(mv_out), 32'h21);
        chk("single/mad", 32'(mad_out), 32'd37);
        fix_en = 1'b0;

        run_frame(3, -1, -1, -1);
        run_frame(0, -1, -1, -1);
        // abort with pix_addr = 7, then a normal frame
        run_frame(2, 8, -1, -1);
        run_frame(1, -1, -1, -1);
        // async reset in the middle of CMP
        run_frame(2, -1, -1, 18);
        run_frame(1, -1, -1, -1);
        // start pulsed while block 1 of 2 is in progress
        run_frame(2, -1, 26, -1);
        run_frame(64, -1, -1, -1);

        for (int i = 0; i < 12; i++) begin
            n  = int'($urandom_range(0, 5));
            ak = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 21 * n - 1)) : -1;
            sk = (n > 0 && $urandom_range(0, 1) == 0) ? int'($urandom_range(0, 21 * n - 1)) : -1;
            run_frame(n, ak, sk, -1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
